// File: rtl/dest_fwd_unit.sv
// Destination-register pipeline (EX/MEM, MEM/WB) with ALU operand forwarding
// selects, load-use stall detection and stall monitoring counters.
module dest_fwd_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic [4:0]  mem_wreg,
    output logic        mem_regwrite,
    output logic        mem_memread,
    output logic [4:0]  wb_wreg,
    output logic        wb_regwrite,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic        stall_err,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    logic stall_q;
    logic mem_live;
    logic wb_live;

    // A stage can only forward when it writes a real (non-zero) register.
    assign mem_live = mem_regwrite && (mem_wreg != 5'd0);
    assign wb_live  = wb_regwrite  && (wb_wreg  != 5'd0);

    // Operand select: the younger EX/MEM result takes priority over MEM/WB.
    always_comb begin
        fwd_a = SEL_RF;
        if (mem_live && (mem_wreg == ex_rs))
            fwd_a = SEL_MEM;
        else if (wb_live && (wb_wreg == ex_rs))
            fwd_a = SEL_WB;

        fwd_b = SEL_RF;
        if (mem_live && (mem_wreg == ex_rt))
            fwd_b = SEL_MEM;
        else if (wb_live && (wb_wreg == ex_rt))
            fwd_b = SEL_WB;
    end

    // Load-use hazard: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        stall = ex_memread && ex_regwrite && (ex_wreg != 5'd0) &&
                ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    end

    // Destination pipeline; keeps advancing during a stall since the bubble is upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wreg     <= 5'd0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            wb_wreg      <= 5'd0;
            wb_regwrite  <= 1'b0;
        end else if (!hold) begin
            mem_wreg     <= ex_wreg;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            wb_wreg      <= mem_wreg;
            wb_regwrite  <= mem_regwrite;
        end
    end

    // Stall history, sticky back-to-back stall flag and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= 1'b0;
            stall_err <= 1'b0;
            stall_cnt <= 16'd0;
        end else if (!hold) begin
            stall_q <= stall;
            if (stall && stall_q)
                stall_err <= 1'b1;
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dest_fwd_unit.sv
// Directed self-checking bench for dest_fwd_unit.
module tb_dest_fwd_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  mem_wreg;
    logic        mem_regwrite;
    logic        mem_memread;
    logic [4:0]  wb_wreg;
    logic        wb_regwrite;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic        stall_err;
    logic [15:0] stall_cnt;

    int vectors;
    int miscompares;

    dest_fwd_unit dut (
        .clk(clk), .rst(rst), .hold(hold),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
        .stall_err(stall_err), .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hold = 0; ex_wreg = 0; ex_regwrite = 0; ex_memread = 0;
        ex_rs = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
    endtask

    // asynchronous pulse placed between clock edges
    task automatic rst_pulse();
        #2 rst = 1;
        #1 rst = 0;
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({mem_wreg, mem_regwrite, mem_memread, wb_wreg, wb_regwrite,
             stall_err, stall_cnt} !== 30'd0) begin
            miscompares++;
            $display("FAIL %s: mem_wreg=%0d mem_rw=%0b mem_mr=%0b wb_wreg=%0d wb_rw=%0b err=%0b cnt=%h, required all 0",
                     tag, mem_wreg, mem_regwrite, mem_memread, wb_wreg, wb_regwrite, stall_err, stall_cnt);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #3;
        check_all_zero("reset_regs");
        vectors++;
        if ({fwd_a, fwd_b, stall} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_comb: fwd_a=%b fwd_b=%b stall=%b, required 00 00 0", fwd_a, fwd_b, stall);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_fwd_mem_wb();
        clear_inputs();
        ex_wreg = 5; ex_regwrite = 1;
        step();
        ex_wreg = 9; ex_rs = 5; #1;
        vectors++;
        if (fwd_a !== 2'b10) begin
            miscompares++;
            $display("FAIL fwd_a_mem: got %b, required 10", fwd_a);
        end
        step();
        ex_rt = 5; #1;
        vectors++;
        if (fwd_a !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_a_wb: got %b, required 01", fwd_a);
        end
        vectors++;
        if (fwd_b !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_b_wb: got %b, required 01", fwd_b);
        end
        vectors++;
        if (mem_wreg !== 5'd9 || wb_wreg !== 5'd5) begin
            miscompares++;
            $display("FAIL pipe_regs: mem_wreg=%0d wb_wreg=%0d, required 9 5", mem_wreg, wb_wreg);
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        ex_wreg = 7; ex_regwrite = 1;
        step();
        step();
        ex_rt = 7; ex_rs = 3; ex_wreg = 0; #1;
        vectors++;
        if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
            miscompares++;
            $display("FAIL priority: fwd_b=%b fwd_a=%b, required 10 00", fwd_b, fwd_a);
        end
    endtask

    task automatic test_r0();
        clear_inputs();
        ex_wreg = 0; ex_regwrite = 1;
        step();
        ex_wreg = 6; ex_regwrite = 0;
        step();
        ex_rs = 0; ex_rt = 6; #1;
        vectors++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            miscompares++;
            $display("FAIL r0_or_nowrite: fwd_a=%b fwd_b=%b, required 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_stall();
        clear_inputs();
        rst_pulse();
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 3; id_rt = 3; #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_set: got %b, required 1", stall);
        end
        step();
        ex_wreg = 0; id_rs = 0; id_rt = 0; #1;
        vectors++;
        if (stall_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL stall_cnt_inc: got %0d, required 1", stall_cnt);
        end
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_r0: got %b, required 0", stall);
        end
        step();
        vectors++;
        if (stall_err !== 1'b0 || stall_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL single_stall: err=%b cnt=%0d, required 0 1", stall_err, stall_cnt);
        end
    endtask

    task automatic test_stall_err();
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 4; id_rs = 4;
        step();
        vectors++;
        if (stall_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_after_one: got %b, required 0", stall_err);
        end
        step();
        vectors++;
        if (stall_err !== 1'b1 || stall_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL err_after_two: err=%b cnt=%0d, required 1 3", stall_err, stall_cnt);
        end
        clear_inputs();
        step();
        step();
        vectors++;
        if (stall_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b, required 1", stall_err);
        end
    endtask

    task automatic test_hold();
        clear_inputs();
        rst_pulse();
        ex_wreg = 11; ex_regwrite = 1;
        step();
        ex_wreg = 12;
        step();
        hold = 1; ex_memread = 1; ex_rs = 12; ex_rt = 11;
        for (int i = 0; i < 3; i++) begin
            ex_wreg = 5'(20 + i); id_rs = 5'(20 + i); #1;
            vectors++;
            if (stall !== 1'b1 || fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
                miscompares++;
                $display("FAIL hold_comb[%0d]: stall=%b fwd_a=%b fwd_b=%b, required 1 10 01",
                         i, stall, fwd_a, fwd_b);
            end
            step();
            vectors++;
            if (mem_wreg !== 5'd12 || wb_wreg !== 5'd11 || stall_cnt !== 16'd0) begin
                miscompares++;
                $display("FAIL hold_regs[%0d]: mem_wreg=%0d wb_wreg=%0d cnt=%0d, required 12 11 0",
                         i, mem_wreg, wb_wreg, stall_cnt);
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        ex_wreg = 8; ex_regwrite = 1; ex_memread = 1;
        step();
        step();
        ex_rs = 8; ex_rt = 8; ex_regwrite = 0; ex_memread = 0; ex_wreg = 0; hold = 1;
        #2 rst = 1;
        #1;
        check_all_zero("async_rst_hold");
        #1 rst = 0; hold = 0;
        step();
        vectors++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            miscompares++;
            $display("FAIL post_rst_fwd: fwd_a=%b fwd_b=%b, required 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_saturate();
        clear_inputs();
        rst_pulse();
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 2; id_rt = 2;
        for (int i = 0; i < 65534; i++) step();
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL cnt_preload: got %h, required fffe", stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (stall_cnt !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL cnt_saturate[%0d]: got %h, required ffff", i, stall_cnt);
            end
        end
        #2 rst = 1;
        #1;
        check_all_zero("async_rst_sat");
        #1 rst = 0;
        clear_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fwd_mem_wb();
        test_priority();
        test_r0();
        test_stall();
        test_stall_err();
        test_hold();
        test_async_reset();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
